pipe_ctrl_unit: RTL and testbench

Pipelined main control unit for the five-stage MIPS datapath: it decodes the opcode/funct in ID into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also handles load-use stalls, jump/branch flushes and global freeze.

It supersedes the purely combinational decoder:
- the bundle is widened for the link register and branch kinds;
- distinct encodings are given to andi/ori/lui/beq/bne/bgez;
- jr is decoded from funct.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/pipe_ctrl_unit_decode.sv | 82 ++++++++
 rtl/pipe_ctrl_unit.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle for the pipelined MIPS main control unit.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00, MEM_WORD = 2'b01, MEM_BYTE = 2'b10, MEM_HALF = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10, BR_BGEZ = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00, M2R_MEM = 2'b01, M2R_PC4 = 2'b10
    } m2r_t;

    typedef enum logic [1:0] {
        JS_SEQ = 2'b00, JS_TARGET = 2'b01, JS_RS = 2'b11
    } jump_sel_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
        ALU_OR    = 3'd3, ALU_LUI = 3'd4, ALU_FUNCT = 3'd5
    } alu_op_t;

    typedef struct packed {
        logic      reg_write;
        m2r_t      mem_to_reg;
        mem_size_t mem_read;
        mem_size_t mem_write;
        branch_t   branch;
        alu_op_t   alu_op;
        logic      alu_src;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Loads and stores share the size in the low two opcode bits (11 word, 00 byte, 01 half).
    function automatic mem_size_t op_mem_size(input logic [5:0] op);
        case (op[1:0])
            2'b11:   return MEM_WORD;
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: opcode/funct/rt to control bundle, destination and legality.
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int RA_W     = 5,
    parameter int LINK_REG = 31
) (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    output ctrl_bundle_t    bundle,
    output logic [RA_W-1:0] dst,
    output logic            legal,
    output logic            reads_rt,
    output jump_sel_t       jump
);

    localparam logic [RA_W-1:0] LINK = RA_W'(LINK_REG);

    always_comb begin
        bundle   = CTRL_BUBBLE;
        dst      = '0;
        legal    = 1'b1;
        reads_rt = 1'b0;
        jump     = JS_SEQ;
        case (opcode)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                if (funct == FN_JR) begin
                    jump = JS_RS;
                end else begin
                    bundle.reg_write = 1'b1;
                    bundle.alu_op    = ALU_FUNCT;
                    dst              = rd;
                end
            end
            OP_LW, OP_LB, OP_LH: begin
                bundle.reg_write  = 1'b1;
                bundle.mem_to_reg = M2R_MEM;
                bundle.mem_read   = op_mem_size(opcode);
                bundle.alu_src    = 1'b1;
                dst               = rt;
            end
            OP_SW, OP_SB, OP_SH: begin
                reads_rt          = 1'b1;
                bundle.mem_write  = op_mem_size(opcode);
                bundle.alu_src    = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_LUI: begin
                bundle.reg_write = 1'b1;
                bundle.alu_src   = 1'b1;
                bundle.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                                   (opcode == OP_ORI)  ? ALU_OR  : ALU_LUI;
                dst              = rt;
            end
            OP_BEQ, OP_BNE: begin
                reads_rt      = 1'b1;
                bundle.branch = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                bundle.alu_op = ALU_SUB;
            end
            // REGIMM only defines bgez; every other rt code is illegal.
            OP_REGIMM: begin
                if (rt == RA_W'(RT_BGEZ)) begin
                    bundle.branch = BR_BGEZ;
                    bundle.alu_op = ALU_SUB;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_J: jump = JS_TARGET;
            OP_JAL: begin
                jump              = JS_TARGET;
                bundle.reg_write  = 1'b1;
                bundle.mem_to_reg = M2R_PC4;
                dst               = LINK;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers, stall/flush/freeze.
import ctrl_pkg::*;

module pipe_ctrl_unit #(
    parameter int RA_W      = 5,
    parameter int LINK_REG  = 31,
    parameter int HAZARD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            branch_taken,
    input  logic            mem_busy,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic [2:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic [1:0]      ex_branch,
    output logic [RA_W-1:0] ex_dst,
    output logic [1:0]      mem_read,
    output logic [1:0]      mem_write,
    output logic            wb_reg_write,
    output logic [1:0]      wb_mem_to_reg,
    output logic [RA_W-1:0] wb_dst,
    output logic [1:0]      jump_sel,
    output logic            illegal_op
);

    ctrl_bundle_t    id_bundle;
    logic [RA_W-1:0] id_dst;
    logic            id_legal;
    logic            id_reads_rt;
    jump_sel_t       id_jump;

    ctrl_decode #(.RA_W(RA_W), .LINK_REG(LINK_REG)) u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .rt       (id_rt),
        .rd       (id_rd),
        .bundle   (id_bundle),
        .dst      (id_dst),
        .legal    (id_legal),
        .reads_rt (id_reads_rt),
        .jump     (id_jump)
    );

    ctrl_bundle_t    ctl_p0;
    logic [RA_W-1:0] dst_p0;
    logic            illegal_p0;
    mem_size_t       mem_read_p1;
    mem_size_t       mem_write_p1;
    logic            reg_write_p1;
    m2r_t            mem_to_reg_p1;
    logic [RA_W-1:0] dst_p1;
    logic            reg_write_p2;
    m2r_t            mem_to_reg_p2;
    logic [RA_W-1:0] dst_p2;

    logic load_use;
    logic kill_id;

    assign load_use = (HAZARD_EN != 0) && (ctl_p0.mem_read != MEM_NONE) && (dst_p0 != '0)
                      && ((dst_p0 == id_rs) || (id_reads_rt && (dst_p0 == id_rt)));
    assign kill_id  = branch_taken || load_use;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        jump_sel   = JS_SEQ;
        if (rst_n) begin
            if (mem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (id_jump != JS_SEQ) begin
                jump_sel   = id_jump;
                ifid_flush = 1'b1;
            end
        end
        // Software-scheduled builds never gate the front end.
        if (HAZARD_EN == 0) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_p0        <= CTRL_BUBBLE;
            dst_p0        <= '0;
            illegal_p0    <= 1'b0;
            mem_read_p1   <= MEM_NONE;
            mem_write_p1  <= MEM_NONE;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= M2R_ALU;
            dst_p1        <= '0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= M2R_ALU;
            dst_p2        <= '0;
        end else if (!mem_busy) begin
            // ID -> EX
            ctl_p0        <= kill_id ? CTRL_BUBBLE : id_bundle;
            dst_p0        <= kill_id ? '0 : id_dst;
            illegal_p0    <= !kill_id && !id_legal;
            // EX -> MEM
            mem_read_p1   <= ctl_p0.mem_read;
            mem_write_p1  <= ctl_p0.mem_write;
            reg_write_p1  <= ctl_p0.reg_write;
            mem_to_reg_p1 <= ctl_p0.mem_to_reg;
            dst_p1        <= dst_p0;
            // MEM -> WB
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            dst_p2        <= dst_p1;
        end
    end

    assign ex_alu_op     = ctl_p0.alu_op;
    assign ex_alu_src    = ctl_p0.alu_src;
    assign ex_branch     = ctl_p0.branch;
    assign ex_dst        = dst_p0;
    assign illegal_op    = illegal_p0;
    assign mem_read      = mem_read_p1;
    assign mem_write     = mem_write_p1;
    assign wb_reg_write  = reg_write_p2;
    assign wb_mem_to_reg = mem_to_reg_p2;
    assign wb_dst        = dst_p2;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: HAZARD_EN=1 and HAZARD_EN=0 instances against an instruction-level model.
module tb_pipe_ctrl_unit;

    localparam int W = 29;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       branch_taken = 1'b0, mem_busy = 1'b0;

    logic       pc_write [2], ifid_write [2], ifid_flush [2], ex_alu_src [2];
    logic       wb_reg_write [2], illegal_op [2];
    logic [2:0] ex_alu_op [2];
    logic [1:0] ex_branch [2], mem_read [2], mem_write [2], wb_mem_to_reg [2], jump_sel [2];
    logic [4:0] ex_dst [2], wb_dst [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_ctrl_unit #(.RA_W(5), .LINK_REG(31), .HAZARD_EN(g == 0 ? 1 : 0)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .opcode        (opcode),
            .funct         (funct),
            .id_rs         (id_rs),
            .id_rt         (id_rt),
            .id_rd         (id_rd),
            .branch_taken  (branch_taken),
            .mem_busy      (mem_busy),
            .pc_write      (pc_write[g]),
            .ifid_write    (ifid_write[g]),
            .ifid_flush    (ifid_flush[g]),
            .ex_alu_op     (ex_alu_op[g]),
            .ex_alu_src    (ex_alu_src[g]),
            .ex_branch     (ex_branch[g]),
            .ex_dst        (ex_dst[g]),
            .mem_read      (mem_read[g]),
            .mem_write     (mem_write[g]),
            .wb_reg_write  (wb_reg_write[g]),
            .wb_mem_to_reg (wb_mem_to_reg[g]),
            .wb_dst        (wb_dst[g]),
            .jump_sel      (jump_sel[g]),
            .illegal_op    (illegal_op[g])
        );
    end

    typedef enum {I_ALU, I_JR, I_LW, I_LB, I_LH, I_SW, I_SB, I_SH, I_ANDI, I_ORI, I_LUI,
                  I_BEQ, I_BNE, I_BGEZ, I_J, I_JAL, I_BAD} mn_t;

    // What an instruction means to the later stages; alu codes: add 0, sub 1, and 2, or 3, lui 4, funct 5.
    typedef struct packed {
        logic       rw;
        logic [1:0] m2r;
        logic [1:0] mrd;
        logic [1:0] mwr;
        logic [1:0] br;
        logic [2:0] alu;
        logic       src;
        logic [4:0] dst;
        logic       ill;
    } stage_t;

    stage_t ex_m [2], mem_m [2], wb_m [2];
    logic [W-1:0] exp_q0 [$], exp_q1 [$];
    int errors = 0, checks = 0, cyc_n = 0;

    logic [5:0] ops [16] = '{6'b000000, 6'b000000, 6'b100011, 6'b100000, 6'b100001, 6'b101011,
                             6'b101000, 6'b101001, 6'b001100, 6'b001101, 6'b001111, 6'b000100,
                             6'b000101, 6'b000001, 6'b000010, 6'b111111};

    function automatic mn_t classify(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
        case (op)
            6'b000000: return (fn == 6'b001000) ? I_JR : I_ALU;
            6'b100011: return I_LW;
            6'b100000: return I_LB;
            6'b100001: return I_LH;
            6'b101011: return I_SW;
            6'b101000: return I_SB;
            6'b101001: return I_SH;
            6'b001100: return I_ANDI;
            6'b001101: return I_ORI;
            6'b001111: return I_LUI;
            6'b000100: return I_BEQ;
            6'b000101: return I_BNE;
            6'b000001: return (rt == 5'd1) ? I_BGEZ : I_BAD;
            6'b000010: return I_J;
            6'b000011: return I_JAL;
            default:   return I_BAD;
        endcase
    endfunction

    function automatic stage_t meaning(input mn_t m, input logic [4:0] rt, input logic [4:0] rd);
        stage_t s = '0;
        case (m)
            I_ALU:  begin s.rw = 1; s.alu = 3'd5; s.dst = rd; end
            I_LW, I_LB, I_LH: begin
                s.rw = 1; s.m2r = 2'b01; s.src = 1; s.dst = rt;
                s.mrd = (m == I_LW) ? 2'b01 : (m == I_LB) ? 2'b10 : 2'b11;
            end
            I_SW, I_SB, I_SH: begin
                s.src = 1;
                s.mwr = (m == I_SW) ? 2'b01 : (m == I_SB) ? 2'b10 : 2'b11;
            end
            I_ANDI: begin s.rw = 1; s.src = 1; s.alu = 3'd2; s.dst = rt; end
            I_ORI:  begin s.rw = 1; s.src = 1; s.alu = 3'd3; s.dst = rt; end
            I_LUI:  begin s.rw = 1; s.src = 1; s.alu = 3'd4; s.dst = rt; end
            I_BEQ:  begin s.br = 2'b01; s.alu = 3'd1; end
            I_BNE:  begin s.br = 2'b10; s.alu = 3'd1; end
            I_BGEZ: begin s.br = 2'b11; s.alu = 3'd1; end
            I_JAL:  begin s.rw = 1; s.m2r = 2'b10; s.dst = 5'd31; end
            I_BAD:  s.ill = 1;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic reads_rt(input mn_t m);
        return m inside {I_ALU, I_JR, I_SW, I_SB, I_SH, I_BEQ, I_BNE};
    endfunction

    function automatic logic [1:0] jump_of(input mn_t m);
        return (m == I_J || m == I_JAL) ? 2'b01 : (m == I_JR) ? 2'b11 : 2'b00;
    endfunction

    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic bt, input logic busy);
        mn_t m;
        stage_t s;
        stage_t nx_ex [2], nx_mem [2], nx_wb [2];
        logic stall, pw, iw, fl;
        logic [1:0] js;
        logic [W-1:0] e;
        rst_n = r; opcode = op; funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
        branch_taken = bt; mem_busy = busy;
        m = classify(op, fn, rt);
        s = meaning(m, rt, rd);
        for (int d = 0; d < 2; d++) begin
            stall = (d == 0) && ex_m[d].mrd != 2'b00 && ex_m[d].dst != 5'd0
                    && (ex_m[d].dst == rs || (reads_rt(m) && ex_m[d].dst == rt));
            pw = 1; iw = 1; fl = 0; js = 2'b00;
            if (r) begin
                if (busy) begin pw = 0; iw = 0; end
                else if (bt) fl = 1;
                else if (stall) begin pw = 0; iw = 0; end
                else if (jump_of(m) != 2'b00) begin js = jump_of(m); fl = 1; end
            end
            if (d == 1) begin pw = 1; iw = 1; end
            e = {pw, iw, fl, js, ex_m[d].alu, ex_m[d].src, ex_m[d].br, ex_m[d].dst,
                 mem_m[d].mrd, mem_m[d].mwr, wb_m[d].rw, wb_m[d].m2r, wb_m[d].dst, ex_m[d].ill};
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            if (!r) begin
                nx_ex[d] = '0; nx_mem[d] = '0; nx_wb[d] = '0;
            end else if (busy) begin
                nx_ex[d] = ex_m[d]; nx_mem[d] = mem_m[d]; nx_wb[d] = wb_m[d];
            end else begin
                nx_wb[d]  = mem_m[d];
                nx_mem[d] = ex_m[d];
                nx_ex[d]  = (bt || stall) ? '0 : s;
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            ex_m[d] = nx_ex[d]; mem_m[d] = nx_mem[d]; wb_m[d] = nx_wb[d];
        end
        cyc_n++;
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic compare_dut(input int d, input logic [W-1:0] e);
        logic [W-1:0] obs;
        obs = {pc_write[d], ifid_write[d], ifid_flush[d], jump_sel[d], ex_alu_op[d], ex_alu_src[d],
               ex_branch[d], ex_dst[d], mem_read[d], mem_write[d], wb_reg_write[d],
               wb_mem_to_reg[d], wb_dst[d], illegal_op[d]};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL cycle%0d dut%0d outputs {pcw,ifw,flush,jsel,alu,src,br,exdst,mrd,mwr,wbrw,m2r,wbdst,ill}: got %b required %b",
                     cyc_n, d, obs, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0) compare_dut(0, exp_q0.pop_front());
        if (exp_q1.size() > 0) compare_dut(1, exp_q1.pop_front());
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            ex_m[d] = '0; mem_m[d] = '0; wb_m[d] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nop(1);
        // lw r2 then add r3,r2,r4 (presented again after the stall)
        cyc(1, 6'b100011, 6'b000000, 5'd1, 5'd2, 5'd0, 0, 0);
        cyc(1, 6'b000000, 6'b100000, 5'd2, 5'd4, 5'd3, 0, 0);
        cyc(1, 6'b000000, 6'b100000, 5'd2, 5'd4, 5'd3, 0, 0);
        nop(3);
        // jal
        cyc(1, 6'b000011, 6'b000000, 5'd0, 5'd0, 5'd0, 0, 0);
        nop(3);
        // branch_taken with a load-use condition in ID
        cyc(1, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0, 0, 0);
        cyc(1, 6'b000000, 6'b100000, 5'd5, 5'd6, 5'd7, 1, 0);
        nop(2);
        // jump squashed by branch_taken, jr, bgez, lui
        cyc(1, 6'b000010, 6'b000000, 5'd0, 5'd0, 5'd0, 1, 0);
        cyc(1, 6'b000000, 6'b001000, 5'd9, 5'd0, 5'd0, 0, 0);
        cyc(1, 6'b000001, 6'b000000, 5'd3, 5'd1, 5'd0, 0, 0);
        cyc(1, 6'b001111, 6'b000000, 5'd0, 5'd8, 5'd0, 0, 0);
        nop(2);
        // sb frozen in MEM for three cycles
        cyc(1, 6'b101000, 6'b000000, 5'd1, 5'd6, 5'd0, 0, 0);
        nop(1);
        repeat (3) cyc(1, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0, 1);
        nop(2);
        // illegal opcode then reset mid-stream, including reset during a freeze
        cyc(1, 6'b111111, 6'b000000, 5'd0, 5'd0, 5'd0, 0, 0);
        nop(1);
        cyc(0, 6'b100011, 6'b000000, 5'd1, 5'd2, 5'd0, 0, 1);
        nop(2);
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 15)];
            fn = ($urandom_range(0, 7) == 0) ? 6'b001000 : 6'($urandom);
            cyc($urandom_range(0, 49) != 0, op, fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d required 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
